// File: rtl/rsa_seq_pkg.sv
// Shared types and constants for the RSA job sequencer slice.
package rsa_seq_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int NBYTES_DEF    = WORD_W_DEF / 8;
  localparam int FRAME_LEN_DEF = 3 * NBYTES_DEF;

  // Status bytes held back for a future framed TX response.
  localparam logic [7:0] TX_ERR_MOD     = 8'hE1;
  localparam logic [7:0] TX_ERR_TIMEOUT = 8'hE2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  function automatic int frame_len(input int word_w);
    return 3 * (word_w / 8);
  endfunction

endpackage

// File: rtl/rsa_byte_serializer.sv
// Streams a loaded word into the TX FIFO LSB first, stalling on tx_full.
module rsa_byte_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_tx_full,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wrreq,
  output logic              o_done
);

  localparam int NBYTES = WORD_W / 8;
  localparam int JW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [WORD_W-1:0] r_word;
  logic [JW-1:0]     r_cnt;
  logic              r_active;
  logic              w_last;

  assign w_last     = (r_cnt == JW'(NBYTES - 1));
  assign o_tx_wrreq = r_active && !i_tx_full;
  assign o_tx_data  = r_word[7:0];
  assign o_done     = o_tx_wrreq && w_last;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_word   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_word   <= i_word;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (o_tx_wrreq) begin
      r_word <= r_word >> 8;
      if (w_last) begin
        r_cnt    <= '0;
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_job_sequencer.sv
// Job controller: loads a key/mod/plaintext frame, runs the modexp engine
// under a watchdog and streams the result bytes out to the TX FIFO.
//   state | meaning
//   IDLE  | waiting for the first byte of a frame
//   LOAD  | popping frame bytes, one per cycle while RX is non-empty
//   CHECK | operands published; reject modulus < 2
//   START | one-cycle engine start pulse
//   WAIT  | waiting for eng_done, watchdog running
//   SEND  | result bytes going to TX
module rsa_job_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_empty,
  output logic              o_rx_rdreq,
  output logic [WORD_W-1:0] o_eng_key,
  output logic [WORD_W-1:0] o_eng_mod,
  output logic [WORD_W-1:0] o_eng_base,
  output logic              o_eng_start,
  input  logic              i_eng_done,
  input  logic [WORD_W-1:0] i_eng_result,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_full,
  output logic              o_tx_wrreq,
  output logic              o_busy,
  output logic [7:0]        o_job_count,
  output logic              o_err_mod,
  output logic              o_err_timeout
);

  localparam int FRAME = frame_len(WORD_W);
  localparam int IW    = $clog2(FRAME);
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state, w_next;
  logic [3*WORD_W-1:0] r_frame;
  logic [IW-1:0]       r_idx;
  logic [TW-1:0]       r_wd;
  logic [WORD_W-1:0]   r_eng_key, r_eng_mod, r_eng_base;
  logic [7:0]          r_job_count;
  logic                r_err_mod, r_err_timeout;
  logic                w_last_byte, w_mod_bad, w_wd_expire;
  logic                w_ser_load, w_ser_done;
  logic [WORD_W-1:0]   w_ser_word;

  assign w_last_byte   = (r_idx == IW'(FRAME - 1));
  assign w_mod_bad     = r_frame[2*WORD_W-1:WORD_W] < WORD_W'(2);
  assign w_wd_expire   = (r_wd == '0);
  assign o_busy        = (r_state != S_IDLE);
  assign o_eng_key     = r_eng_key;
  assign o_eng_mod     = r_eng_mod;
  assign o_eng_base    = r_eng_base;
  assign o_job_count   = r_job_count;
  assign o_err_mod     = r_err_mod;
  assign o_err_timeout = r_err_timeout;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_rx_rdreq  = 1'b0;
    o_eng_start = 1'b0;
    w_ser_load  = 1'b0;
    w_ser_word  = '0;
    case (r_state)
      S_IDLE:  if (!i_rx_empty) w_next = S_LOAD;
      S_LOAD: begin
        o_rx_rdreq = !i_rx_empty;
        if (!i_rx_empty && w_last_byte) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_mod_bad) begin
          w_ser_load = 1'b1;
          w_next     = S_SEND;
        end else begin
          w_next = S_START;
        end
      end
      S_START: begin
        o_eng_start = 1'b1;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse in the expiry cycle still completes the job.
        if (i_eng_done) begin
          w_ser_load = 1'b1;
          w_ser_word = i_eng_result;
          w_next     = S_SEND;
        end else if (w_wd_expire) begin
          w_next = S_IDLE;
        end
      end
      S_SEND:  if (w_ser_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame shifts in from the top so byte 0 lands in the key LSB.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_frame       <= '0;
      r_idx         <= '0;
      r_wd          <= '0;
      r_eng_key     <= '0;
      r_eng_mod     <= '0;
      r_eng_base    <= '0;
      r_job_count   <= '0;
      r_err_mod     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (o_rx_rdreq) begin
        r_frame <= {i_rx_data, r_frame[3*WORD_W-1:8]};
        r_idx   <= w_last_byte ? '0 : r_idx + 1'b1;
      end
      if (r_state == S_CHECK) begin
        r_eng_key  <= r_frame[WORD_W-1:0];
        r_eng_mod  <= r_frame[2*WORD_W-1:WORD_W];
        r_eng_base <= r_frame[3*WORD_W-1:2*WORD_W];
        if (w_mod_bad) r_err_mod <= 1'b1;
      end
      if (r_state == S_START) begin
        r_wd <= TW'(TIMEOUT - 1);
      end else if (r_state == S_WAIT && !i_eng_done) begin
        if (w_wd_expire) r_err_timeout <= 1'b1;
        else             r_wd <= r_wd - 1'b1;
      end
      if (r_state == S_SEND && w_ser_done) r_job_count <= r_job_count + 8'd1;
    end
  end

  rsa_byte_serializer #(.WORD_W(WORD_W)) u_ser (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_ser_load),
    .i_word     (w_ser_word),
    .i_tx_full  (i_tx_full),
    .o_tx_data  (o_tx_data),
    .o_tx_wrreq (o_tx_wrreq),
    .o_done     (w_ser_done)
  );

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Scoreboard bench for rsa_job_sequencer: directed frames, engine stand-in,
// RX FIFO model and TX/engine monitors.
module tb_rsa_job_sequencer;

  localparam int W      = 32;
  localparam int TMO    = 20;
  localparam int ENG_L  = 10;
  localparam int BUDGET = 400;

  typedef struct {
    logic [W-1:0] k;
    logic [W-1:0] m;
    logic [W-1:0] b;
  } op_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_empty = 1'b1;
  logic         rx_rdreq;
  logic [W-1:0] eng_key, eng_mod, eng_base;
  logic         eng_start;
  logic         eng_done = 1'b0;
  logic [W-1:0] eng_result = '0;
  logic [7:0]   tx_data;
  logic         tx_full = 1'b0;
  logic         tx_wrreq;
  logic         busy;
  logic [7:0]   job_count;
  logic         err_mod, err_timeout;

  int   checks = 0;
  int   errors = 0;
  int   tx_seen = 0;
  int   rx_pops = 0;
  bit   eng_hang = 1'b0;
  bit   pop_pending = 1'b0;
  logic [7:0] rx_fifo[$];
  logic [7:0] exp_tx[$];
  op_t        exp_op[$];

  rsa_job_sequencer #(.WORD_W(W), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (reset),
    .i_rx_data     (rx_data),
    .i_rx_empty    (rx_empty),
    .o_rx_rdreq    (rx_rdreq),
    .o_eng_key     (eng_key),
    .o_eng_mod     (eng_mod),
    .o_eng_base    (eng_base),
    .o_eng_start   (eng_start),
    .i_eng_done    (eng_done),
    .i_eng_result  (eng_result),
    .o_tx_data     (tx_data),
    .i_tx_full     (tx_full),
    .o_tx_wrreq    (tx_wrreq),
    .o_busy        (busy),
    .o_job_count   (job_count),
    .o_err_mod     (err_mod),
    .o_err_timeout (err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [63:0] r, x;
    r = 64'(1) % 64'(m);
    x = 64'(b) % 64'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % 64'(m);
      x = (x * x) % 64'(m);
    end
    return r[W-1:0];
  endfunction

  // RX FIFO model: show-ahead head byte, pop decided from the settled rdreq.
  always @(negedge clock) pop_pending = rx_rdreq && !rx_empty;

  always @(posedge clock) begin
    if (pop_pending && rx_fifo.size() > 0) begin
      void'(rx_fifo.pop_front());
      rx_pops++;
    end
    #1;
    rx_empty = (rx_fifo.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_fifo[0];
  end

  // Engine stand-in: answers L cycles after start unless hung.
  always @(negedge clock) begin
    if (reset && eng_start && !eng_hang) begin
      logic [W-1:0] k, m, b;
      k = eng_key; m = eng_mod; b = eng_base;
      repeat (ENG_L) @(posedge clock);
      #1;
      eng_done   = 1'b1;
      eng_result = modexp(b, k, m);
      @(posedge clock);
      #1;
      eng_done   = 1'b0;
      eng_result = '0;
    end
  end

  // Monitor: compares every presented TX byte and engine launch to the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (rx_rdreq) chk("rdreq_while_empty", W'(rx_empty), '0);
      if (tx_wrreq) begin
        chk("wrreq_while_full", W'(tx_full), '0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte %0h expected no write", tx_data);
        end else begin
          chk("tx_byte", W'(tx_data), W'(exp_tx.pop_front()));
        end
        tx_seen++;
      end
      if (eng_start) begin
        if (exp_op.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected: got eng_start expected none");
        end else begin
          op_t e;
          e = exp_op.pop_front();
          chk("eng_key", eng_key, e.k);
          chk("eng_mod", eng_mod, e.m);
          chk("eng_base", eng_base, e.b);
        end
      end
    end
  end

  task automatic issue_job(input logic [W-1:0] key, input logic [W-1:0] md,
                           input logic [W-1:0] pt, input bit exp_start,
                           input bit exp_tx_en, input logic [W-1:0] exp_res,
                           input int gap);
    logic [7:0] bytes[$];
    logic [W-1:0] words[3];
    op_t o;
    words[0] = key; words[1] = md; words[2] = pt;
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < W / 8; b++) bytes.push_back(8'(words[w] >> (8 * b)));
    if (exp_start) begin
      o.k = key; o.m = md; o.b = pt;
      exp_op.push_back(o);
    end
    if (exp_tx_en)
      for (int b = 0; b < W / 8; b++) exp_tx.push_back(8'(exp_res >> (8 * b)));
    if (gap == 0) begin
      foreach (bytes[i]) rx_fifo.push_back(bytes[i]);
    end else begin
      foreach (bytes[i]) begin
        int n;
        rx_fifo.push_back(bytes[i]);
        n = 0;
        while (rx_fifo.size() != 0 && n < BUDGET) begin
          @(negedge clock);
          n++;
        end
        if (n >= BUDGET) chk("rx_drain_timeout", W'(rx_fifo.size()), '0);
        repeat (gap) @(posedge clock);
      end
    end
  endtask

  task automatic run_until_idle();
    int n;
    repeat (4) @(negedge clock);
    n = 0;
    while ((busy || rx_fifo.size() != 0) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) chk("idle_timeout", W'(busy), '0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", W'(busy), '0);
    chk("rst_job_count", W'(job_count), '0);
    chk("rst_eng_start", W'(eng_start), '0);
    chk("rst_tx_wrreq", W'(tx_wrreq), '0);
    chk("rst_err_mod", W'(err_mod), '0);
    chk("rst_err_timeout", W'(err_timeout), '0);
    @(posedge clock); #1 reset = 1'b1;

    // Basic job: 4^7 mod 33 = 16
    issue_job(7, 33, 4, 1, 1, 32'h10, 0);
    run_until_idle();
    chk("basic_job_count", W'(job_count), 1);
    chk("basic_busy", W'(busy), '0);

    // Back-to-back frames: 12^5 mod 1000 = 832 = 0x340, then 0x10
    issue_job(5, 1000, 12, 1, 1, 32'h340, 0);
    issue_job(7, 33, 4, 1, 1, 32'h10, 0);
    run_until_idle();
    chk("b2b_job_count", W'(job_count), 3);

    // RX starvation with 3-cycle gaps
    issue_job(7, 33, 4, 1, 1, 32'h10, 3);
    run_until_idle();
    chk("starve_job_count", W'(job_count), 4);
    chk("starve_no_timeout", W'(err_timeout), '0);

    // TX back-pressure over byte 2
    tx_seen = 0;
    issue_job(7, 33, 4, 1, 1, 32'h10, 0);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (tx_seen < 2 && n < BUDGET);
    if (n >= BUDGET) chk("bp_wait_timeout", W'(tx_seen), 2);
    tx_full = 1'b1;
    repeat (5) @(posedge clock);
    #1 tx_full = 1'b0;
    run_until_idle();
    chk("bp_tx_count", W'(tx_seen), 4);
    chk("bp_job_count", W'(job_count), 5);

    // Modulus error path, then the boundary mod=2 (5^3 mod 2 = 1)
    issue_job(9, 1, 5, 0, 1, 32'h0, 0);
    run_until_idle();
    chk("moderr_flag", W'(err_mod), 1);
    chk("moderr_job_count", W'(job_count), 6);
    issue_job(3, 2, 5, 1, 1, 32'h1, 0);
    run_until_idle();
    chk("mod2_job_count", W'(job_count), 7);

    // Watchdog: engine never answers
    eng_hang = 1'b1;
    issue_job(3, 7, 2, 1, 0, 32'h0, 0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!eng_start && n < BUDGET);
    if (n >= BUDGET) chk("wd_start_timeout", W'(eng_start), 1);
    repeat (TMO) @(posedge clock);
    @(negedge clock);
    chk("wd_before_expiry", W'(err_timeout), '0);
    chk("wd_busy_before", W'(busy), 1);
    @(negedge clock);
    chk("wd_expired", W'(err_timeout), 1);
    chk("wd_idle", W'(busy), '0);
    chk("wd_job_count", W'(job_count), 7);
    eng_hang = 1'b0;
    // Recovery: 2^3 mod 7 = 1
    issue_job(3, 7, 2, 1, 1, 32'h1, 0);
    run_until_idle();
    chk("wd_recover_count", W'(job_count), 8);

    // Reset in the middle of LOAD
    rx_pops = 0;
    begin
      logic [7:0] fb[12];
      fb = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hE8, 8'h03, 8'h00, 8'h00,
             8'h0C, 8'h00, 8'h00, 8'h00};
      foreach (fb[i]) rx_fifo.push_back(fb[i]);
    end
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (rx_pops < 5 && n < BUDGET);
    if (n >= BUDGET) chk("rst_load_timeout", W'(rx_pops), 5);
    reset = 1'b0;
    rx_fifo.delete();
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_rdreq", W'(rx_rdreq), '0);
    chk("mid_rst_job_count", W'(job_count), '0);
    chk("mid_rst_err_mod", W'(err_mod), '0);
    chk("mid_rst_err_timeout", W'(err_timeout), '0);
    chk("mid_rst_eng_mod", eng_mod, '0);
    chk("mid_rst_tx_data", W'(tx_data), '0);
    @(posedge clock); #1 reset = 1'b1;
    issue_job(5, 1000, 12, 1, 1, 32'h340, 0);
    run_until_idle();
    chk("post_rst_job_count", W'(job_count), 1);
    chk("post_rst_err_mod", W'(err_mod), '0);

    chk("tx_queue_drained", W'(exp_tx.size()), '0);
    chk("op_queue_drained", W'(exp_op.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
